// File: rtl/request_fifo_pkg.sv
// Package req_pkg: request word layout shared by the requester and request_fifo.
// Word layout: [11:8] opcode, [7:6] source id, [5:0] page id.
package req_pkg;

  localparam int unsigned REQ_W    = 12;
  localparam int unsigned OP_MSB   = 11;
  localparam int unsigned OP_LSB   = 8;
  localparam int unsigned SRC_MSB  = 7;
  localparam int unsigned SRC_LSB  = 6;
  localparam int unsigned PAGE_MSB = 5;
  localparam int unsigned PAGE_LSB = 0;
  localparam int unsigned OP_W     = OP_MSB - OP_LSB + 1;
  localparam int unsigned ID_W     = SRC_MSB - SRC_LSB + 1;
  localparam int unsigned PAGE_W   = PAGE_MSB - PAGE_LSB + 1;

  typedef logic [REQ_W-1:0] req_word_t;

  // Field extractors for consumers of the request word.
  function automatic logic [OP_W-1:0] req_opcode(input req_word_t w);
    return w[OP_MSB:OP_LSB];
  endfunction

  function automatic logic [ID_W-1:0] req_source(input req_word_t w);
    return w[SRC_MSB:SRC_LSB];
  endfunction

  function automatic logic [PAGE_W-1:0] req_page(input req_word_t w);
    return w[PAGE_MSB:PAGE_LSB];
  endfunction

endpackage

// File: rtl/request_fifo_ram.sv
// request_fifo_ram: DEPTH x DATA_W storage, one synchronous write port and
// one asynchronous read port. No reset: contents are only meaningful
// between the FIFO pointers.
// Ports:
//   clk      in  system clock
//   i_we     in  write enable
//   i_waddr  in  write index
//   i_wdata  in  write data
//   i_raddr  in  read index
//   o_rdata  out read data (combinational from i_raddr)
module request_fifo_ram #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned DATA_W = 12,
  parameter int unsigned AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [AW-1:0]     i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [AW-1:0]     i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // Asynchronous read port.
  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/request_fifo.sv
// request_fifo: per-requester buffer of 12-bit page requests.
// Option macro: REQUEST_FIFO_FWFT_EN
//   defined   -> first-word-fall-through: dataOut_req shows the head whenever
//                non-empty (0 when empty), read_req pops it.
//   undefined -> standard: dataOut_req is a register loaded on an accepted read.
// Ports:
//   clk             in   rising-edge clock
//   reset           in   asynchronous active-low reset
//   dataIn_req      in   request word to push
//   write_req       in   push strobe
//   full_req        out  count == DEPTH
//   almost_full_req out  count >= DEPTH-AF_MARGIN
//   read_req        in   pop strobe
//   dataOut_req     out  head / popped request word
//   empty_req       out  count == 0
//   count_req       out  occupancy
//   overflow_req    out  sticky: write attempted while full
//   underflow_req   out  sticky: read attempted while empty
module request_fifo
  import req_pkg::*;
#(
  parameter int unsigned DEPTH     = 16,
  parameter int unsigned AF_MARGIN = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  req_word_t                dataIn_req,
  input  logic                     write_req,
  output logic                     full_req,
  output logic                     almost_full_req,
  input  logic                     read_req,
  output req_word_t                dataOut_req,
  output logic                     empty_req,
  output logic [$clog2(DEPTH):0]   count_req,
  output logic                     overflow_req,
  output logic                     underflow_req
);

  localparam int unsigned IDX_W    = $clog2(DEPTH);
  localparam int unsigned PTR_W    = IDX_W + 1;
  localparam int unsigned AF_LEVEL = DEPTH - AF_MARGIN;

  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic             r_overflow;
  logic             r_underflow;
  logic [PTR_W-1:0] w_count;
  logic             w_wr_acc;
  logic             w_rd_acc;
  req_word_t        w_rdata;

  // Occupancy and flags decode from the registered pointers; the extra MSB
  // distinguishes full from empty when the indices match.
  assign w_count         = r_wr_ptr - r_rd_ptr;
  assign count_req       = w_count;
  assign empty_req       = (r_wr_ptr == r_rd_ptr);
  assign full_req        = (r_wr_ptr[IDX_W] != r_rd_ptr[IDX_W]) &&
                           (r_wr_ptr[IDX_W-1:0] == r_rd_ptr[IDX_W-1:0]);
  assign almost_full_req = (32'(w_count) >= AF_LEVEL);
  assign overflow_req    = r_overflow;
  assign underflow_req   = r_underflow;

  assign w_wr_acc = write_req && !full_req;
  assign w_rd_acc = read_req && !empty_req;

  request_fifo_ram #(
    .DEPTH  (DEPTH),
    .DATA_W (REQ_W),
    .AW     (IDX_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_wr_acc),
    .i_waddr (r_wr_ptr[IDX_W-1:0]),
    .i_wdata (dataIn_req),
    .i_raddr (r_rd_ptr[IDX_W-1:0]),
    .o_rdata (w_rdata)
  );

  // Pointers and sticky error flags. Rejected strobes never move a pointer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_acc)              r_wr_ptr    <= r_wr_ptr + PTR_W'(1);
      if (w_rd_acc)              r_rd_ptr    <= r_rd_ptr + PTR_W'(1);
      if (write_req && full_req) r_overflow  <= 1'b1;
      if (read_req && empty_req) r_underflow <= 1'b1;
    end
  end

`ifdef REQUEST_FIFO_FWFT_EN
  // Head word falls through; forced to 0 so stale RAM never leaks out.
  assign dataOut_req = empty_req ? '0 : w_rdata;
`else
  req_word_t r_dout;

  // Output register captures the head on each accepted read.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        r_dout <= '0;
    else if (w_rd_acc) r_dout <= w_rdata;
  end

  assign dataOut_req = r_dout;
`endif

endmodule
